// File: rtl/vend_pkg.sv
// Shared types, field layout and table-word helpers for the vending controller.
package vend_pkg;

   localparam int N_ITEMS    = 8;
   localparam int ITEM_W     = 11;
   localparam int PRICE_W    = 6;
   localparam int STOCK_W    = 5;
   localparam int CREDIT_W   = 8;
   localparam int CREDIT_MAX = 255;
   localparam int SEL_W      = 3;
   localparam int PRICE_LSB  = 0;
   localparam int STOCK_LSB  = 6;

   typedef enum logic [2:0] {
      IDLE,
      CREDIT,
      CHECK,
      DISPENSE,
      CHANGE
   } vendState;

   typedef logic [ITEM_W-1:0] itemWord;

   function automatic logic [PRICE_W-1:0] price_of(input itemWord word);
      return word[PRICE_LSB +: PRICE_W];
   endfunction

   function automatic logic [STOCK_W-1:0] stock_of(input itemWord word);
      return word[STOCK_LSB +: STOCK_W];
   endfunction

endpackage

// File: rtl/vend_if.sv
// Handshake bundle between the vending front panel and the sequencing controller.
interface vend_if;
   import vend_pkg::*;

   logic                        load;
   logic [N_ITEMS*ITEM_W-1:0]   stuff_data;
   logic                        coin_valid;
   logic [PRICE_W-1:0]          coin_value;
   logic                        sel_valid;
   logic [SEL_W-1:0]            sel_item;
   logic                        cancel;
   logic                        coin_reject;
   logic                        dispense_valid;
   logic [SEL_W-1:0]            dispense_item;
   logic                        change_valid;
   logic [CREDIT_W-1:0]         change_amount;
   logic                        err_soldout;
   logic                        err_funds;
   logic [CREDIT_W-1:0]         credit;
   logic                        busy;

   modport master (
      output load, stuff_data, coin_valid, coin_value, sel_valid, sel_item, cancel,
      input  coin_reject, dispense_valid, dispense_item, change_valid, change_amount,
             err_soldout, err_funds, credit, busy
   );

   modport slave (
      input  load, stuff_data, coin_valid, coin_value, sel_valid, sel_item, cancel,
      output coin_reject, dispense_valid, dispense_item, change_valid, change_amount,
             err_soldout, err_funds, credit, busy
   );

endinterface

// File: rtl/vend_stock_table.sv
// Item table: parallel load of all slots, single-slot stock decrement, combinational read.
module VendStockTableUnused;
endmodule

module vend_stock_table
   import vend_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic [N_ITEMS*ITEM_W-1:0] loadData,
   input  logic                      decEn,
   input  logic [SEL_W-1:0]          decIdx,
   input  logic [SEL_W-1:0]          rdIdx,
   output itemWord                   rdWord
);

   itemWord entries [N_ITEMS];

   // The stock guard keeps a stray decrement from wrapping an empty slot to 31.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            entries[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            entries[i] <= loadData[i*ITEM_W +: ITEM_W];
         end
      end else if (decEn && (stock_of(entries[decIdx]) != '0)) begin
         entries[decIdx][STOCK_LSB +: STOCK_W] <= stock_of(entries[decIdx]) - 1'b1;
      end
   end

   assign rdWord = entries[rdIdx];

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, selection check, dispense and change, all outputs registered.
module vend_controller
   import vend_pkg::*;
(
   input logic   clock,
   input logic   reset,
   vend_if.slave bus
);

   localparam logic [CREDIT_W:0] CreditLimit = (CREDIT_W+1)'(CREDIT_MAX);

   vendState            state;
   logic [SEL_W-1:0]    selLatched;
   itemWord             selWord;
   logic [PRICE_W-1:0]  selPrice;
   logic [STOCK_W-1:0]  selStock;
   logic                inEntry;
   logic                coinPresent;
   logic                coinFits;
   logic                acceptCoin;
   logic [CREDIT_W:0]   coinSum;
   logic [CREDIT_W-1:0] creditAfterCoin;
   logic                canAfford;
   logic                tableLoad;
   logic                decEn;

   vend_stock_table stockTable (
      .clock    (clock),
      .reset    (reset),
      .load     (tableLoad),
      .loadData (bus.stuff_data),
      .decEn    (decEn),
      .decIdx   (selLatched),
      .rdIdx    (selLatched),
      .rdWord   (selWord)
   );

   // Coin arithmetic runs one bit wide so an overflowing coin is detected, not wrapped.
   always_comb begin
      selPrice        = price_of(selWord);
      selStock        = stock_of(selWord);
      inEntry         = (state == IDLE) || (state == CREDIT);
      coinPresent     = bus.coin_valid && (bus.coin_value != '0);
      coinSum         = {1'b0, bus.credit} + (CREDIT_W+1)'(bus.coin_value);
      coinFits        = (coinSum <= CreditLimit);
      acceptCoin      = inEntry && coinPresent && coinFits;
      creditAfterCoin = acceptCoin ? coinSum[CREDIT_W-1:0] : bus.credit;
      canAfford       = (bus.credit >= CREDIT_W'(selPrice));
      tableLoad       = bus.load && (state == IDLE);
      decEn           = (state == CHECK) && (selStock != '0) && canAfford;
   end

   // Pulses are set on the edge that enters the state they belong to, so dispense
   // shows during DISPENSE and change during CHANGE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         selLatched         <= '0;
         bus.coin_reject    <= 1'b0;
         bus.dispense_valid <= 1'b0;
         bus.dispense_item  <= '0;
         bus.change_valid   <= 1'b0;
         bus.change_amount  <= '0;
         bus.err_soldout    <= 1'b0;
         bus.err_funds      <= 1'b0;
         bus.credit         <= '0;
         bus.busy           <= 1'b0;
      end else begin
         bus.coin_reject    <= 1'b0;
         bus.dispense_valid <= 1'b0;
         bus.change_valid   <= 1'b0;
         bus.err_soldout    <= 1'b0;
         bus.err_funds      <= 1'b0;
         unique case (state)
            IDLE, CREDIT: begin
               bus.credit      <= creditAfterCoin;
               bus.coin_reject <= coinPresent && !coinFits;
               if ((state == CREDIT) && bus.cancel) begin
                  state             <= CHANGE;
                  bus.busy          <= 1'b1;
                  bus.change_valid  <= (creditAfterCoin != '0);
                  bus.change_amount <= creditAfterCoin;
                  bus.credit        <= '0;
               end else if (bus.sel_valid) begin
                  selLatched <= bus.sel_item;
                  state      <= CHECK;
                  bus.busy   <= 1'b1;
               end else if (acceptCoin) begin
                  state <= CREDIT;
               end
            end
            CHECK: begin
               bus.coin_reject <= bus.coin_valid;
               if (selStock == '0) begin
                  bus.err_soldout <= 1'b1;
                  state           <= (bus.credit == '0) ? IDLE : CREDIT;
                  bus.busy        <= 1'b0;
               end else if (!canAfford) begin
                  bus.err_funds <= 1'b1;
                  state         <= (bus.credit == '0) ? IDLE : CREDIT;
                  bus.busy      <= 1'b0;
               end else begin
                  bus.dispense_valid <= 1'b1;
                  bus.dispense_item  <= selLatched;
                  bus.credit         <= bus.credit - CREDIT_W'(selPrice);
                  state              <= DISPENSE;
               end
            end
            DISPENSE: begin
               bus.coin_reject <= bus.coin_valid;
               if (bus.credit != '0) begin
                  bus.change_valid  <= 1'b1;
                  bus.change_amount <= bus.credit;
                  bus.credit        <= '0;
               end
               state <= CHANGE;
            end
            CHANGE: begin
               bus.coin_reject <= bus.coin_valid;
               state           <= IDLE;
               bus.busy        <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_controller.sv
// Scenario bench for vend_controller: expected pulses queued at stimulus time, matched against a pulse monitor.
module tb_vend_controller;
   import vend_pkg::*;

   localparam logic [2:0] EvReject   = 3'd1;
   localparam logic [2:0] EvDispense = 3'd2;
   localparam logic [2:0] EvChange   = 3'd3;
   localparam logic [2:0] EvSoldout  = 3'd4;
   localparam logic [2:0] EvFunds    = 3'd5;

   typedef struct packed {
      logic [2:0] kind;
      logic [7:0] val;
   } evT;

   logic clock = 1'b0;
   logic reset = 1'b1;
   vend_if bus ();

   evT expQ[$];
   evT obsQ[$];
   int vectors     = 0;
   int miscompares = 0;
   logic [N_ITEMS*ITEM_W-1:0] tableImg;

   vend_controller dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Every output pulse seen mid-cycle is logged for the scoreboard.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.coin_reject)    obsQ.push_back('{EvReject, 8'd0});
         if (bus.dispense_valid) obsQ.push_back('{EvDispense, 8'(bus.dispense_item)});
         if (bus.change_valid)   obsQ.push_back('{EvChange, bus.change_amount});
         if (bus.err_soldout)    obsQ.push_back('{EvSoldout, 8'd0});
         if (bus.err_funds)      obsQ.push_back('{EvFunds, 8'd0});
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic cv, input logic [5:0] val, input logic sv,
                                input logic [2:0] si, input logic cn);
      bus.coin_valid = cv;
      bus.coin_value = val;
      bus.sel_valid  = sv;
      bus.sel_item   = si;
      bus.cancel     = cn;
      tick();
      bus.coin_valid = 1'b0;
      bus.coin_value = '0;
      bus.sel_valid  = 1'b0;
      bus.sel_item   = '0;
      bus.cancel     = 1'b0;
      bus.load       = 1'b0;
   endtask

   task automatic setSlot(input int idx, input int stock, input int price);
      tableImg[idx*ITEM_W +: ITEM_W] = {5'(stock), 6'(price)};
   endtask

   task automatic doResetAndLoad();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      expQ.delete();
      obsQ.delete();
      bus.load       = 1'b1;
      bus.stuff_data = tableImg;
      tick();
      bus.load = 1'b0;
   endtask

   task automatic test_reset();
      itemWord w;
      bus.load       = 1'b1;
      bus.stuff_data = {N_ITEMS*ITEM_W{1'b1}};
      reset          = 1'b1;
      tick();
      tick();
      vectors++;
      if ({bus.coin_reject, bus.dispense_valid, bus.change_valid, bus.err_soldout,
           bus.err_funds, bus.busy} !== 6'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_pulses: got %b, expected 000000",
                  {bus.coin_reject, bus.dispense_valid, bus.change_valid, bus.err_soldout,
                   bus.err_funds, bus.busy});
      end
      vectors++;
      if ({bus.credit, bus.change_amount, bus.dispense_item} !== 19'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_values: credit %0d change %0d item %0d, expected all 0",
                  bus.credit, bus.change_amount, bus.dispense_item);
      end
      vectors++;
      if (dut.state !== IDLE) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %0d, expected IDLE", dut.state);
      end
      for (int i = 0; i < N_ITEMS; i++) begin
         w = dut.stockTable.entries[i];
         vectors++;
         if (w !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_table[%0d]: got %h, expected 000", i, w);
         end
      end
      bus.load = 1'b0;
      reset    = 1'b0;
      tick();
   endtask

   task automatic test_purchase();
      evT e, o;
      itemWord w;
      tableImg = '0;
      setSlot(2, 3, 10);
      doResetAndLoad();
      applyStimulus(1, 5, 0, 0, 0);
      applyStimulus(1, 5, 0, 0, 0);
      applyStimulus(1, 5, 0, 0, 0);
      vectors++;
      if (bus.credit !== 8'd15) begin
         miscompares++;
         $display("[TB] FAIL purchase_credit: got %0d, expected 15", bus.credit);
      end
      expQ.push_back('{EvDispense, 8'd2});
      expQ.push_back('{EvChange, 8'd5});
      applyStimulus(0, 0, 1, 2, 0);
      vectors++;
      if ({bus.busy, bus.dispense_valid} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL purchase_t1: busy/dispense %b, expected 10", {bus.busy, bus.dispense_valid});
      end
      tick();
      vectors++;
      if ({bus.dispense_valid, bus.dispense_item} !== 4'b1_010) begin
         miscompares++;
         $display("[TB] FAIL purchase_t2: valid %b item %0d, expected 1 item 2",
                  bus.dispense_valid, bus.dispense_item);
      end
      tick();
      vectors++;
      if ({bus.change_valid, bus.change_amount} !== {1'b1, 8'd5}) begin
         miscompares++;
         $display("[TB] FAIL purchase_t3: change %b amount %0d, expected 1 amount 5",
                  bus.change_valid, bus.change_amount);
      end
      tick();
      tick();
      w = dut.stockTable.entries[2];
      vectors++;
      if ({stock_of(w), bus.credit, bus.busy} !== {5'd2, 8'd0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL purchase_after: stock %0d credit %0d busy %b, expected 2 0 0",
                  stock_of(w), bus.credit, bus.busy);
      end
      vectors++;
      if (obsQ.size() !== expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL purchase_evcount: got %0d events, expected %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front();
         o = obsQ.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL purchase_event: got kind %0d val %0d, expected kind %0d val %0d",
                     o.kind, o.val, e.kind, e.val);
         end
      end
   endtask

   task automatic test_soldout();
      evT e, o;
      tableImg = '0;
      setSlot(4, 0, 3);
      doResetAndLoad();
      applyStimulus(1, 10, 0, 0, 0);
      applyStimulus(1, 10, 0, 0, 0);
      expQ.push_back('{EvSoldout, 8'd0});
      applyStimulus(0, 0, 1, 4, 0);
      tick();
      vectors++;
      if ({bus.err_soldout, bus.credit, bus.busy} !== {1'b1, 8'd20, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL soldout_pulse: err %b credit %0d busy %b, expected 1 20 0",
                  bus.err_soldout, bus.credit, bus.busy);
      end
      vectors++;
      if (dut.state !== CREDIT) begin
         miscompares++;
         $display("[TB] FAIL soldout_state: got %0d, expected CREDIT", dut.state);
      end
      expQ.push_back('{EvChange, 8'd20});
      applyStimulus(0, 0, 0, 0, 1);
      tick();
      tick();
      vectors++;
      if (obsQ.size() !== expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL soldout_evcount: got %0d events, expected %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front();
         o = obsQ.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL soldout_event: got kind %0d val %0d, expected kind %0d val %0d",
                     o.kind, o.val, e.kind, e.val);
         end
      end
   endtask

   task automatic test_funds();
      evT e, o;
      tableImg = '0;
      setSlot(1, 2, 10);
      doResetAndLoad();
      applyStimulus(1, 6, 0, 0, 0);
      expQ.push_back('{EvFunds, 8'd0});
      applyStimulus(0, 0, 1, 1, 0);
      tick();
      vectors++;
      if ({bus.err_funds, bus.credit} !== {1'b1, 8'd6}) begin
         miscompares++;
         $display("[TB] FAIL funds_pulse: err %b credit %0d, expected 1 6", bus.err_funds, bus.credit);
      end
      applyStimulus(1, 4, 0, 0, 0);
      expQ.push_back('{EvDispense, 8'd1});
      applyStimulus(0, 0, 1, 1, 0);
      tick();
      tick();
      vectors++;
      if ({bus.change_valid, bus.credit} !== {1'b0, 8'd0}) begin
         miscompares++;
         $display("[TB] FAIL funds_nochange: change %b credit %0d, expected 0 0",
                  bus.change_valid, bus.credit);
      end
      tick();
      tick();
      vectors++;
      if (obsQ.size() !== expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL funds_evcount: got %0d events, expected %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front();
         o = obsQ.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL funds_event: got kind %0d val %0d, expected kind %0d val %0d",
                     o.kind, o.val, e.kind, e.val);
         end
      end
   endtask

   task automatic test_overflow();
      evT e, o;
      tableImg = '0;
      doResetAndLoad();
      applyStimulus(1, 63, 0, 0, 0);
      applyStimulus(1, 63, 0, 0, 0);
      applyStimulus(1, 63, 0, 0, 0);
      applyStimulus(1, 61, 0, 0, 0);
      expQ.push_back('{EvReject, 8'd0});
      applyStimulus(1, 10, 0, 0, 0);
      vectors++;
      if ({bus.coin_reject, bus.credit} !== {1'b1, 8'd250}) begin
         miscompares++;
         $display("[TB] FAIL overflow_reject: reject %b credit %0d, expected 1 250",
                  bus.coin_reject, bus.credit);
      end
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 5, 0, 0, 0);
      vectors++;
      if ({bus.coin_reject, bus.credit} !== {1'b0, 8'd255}) begin
         miscompares++;
         $display("[TB] FAIL overflow_max: reject %b credit %0d, expected 0 255",
                  bus.coin_reject, bus.credit);
      end
      expQ.push_back('{EvReject, 8'd0});
      applyStimulus(1, 1, 0, 0, 0);
      expQ.push_back('{EvChange, 8'd255});
      applyStimulus(0, 0, 0, 0, 1);
      tick();
      vectors++;
      if ({bus.credit, bus.busy} !== {8'd0, 1'b0} || dut.state !== IDLE) begin
         miscompares++;
         $display("[TB] FAIL overflow_cancel: credit %0d busy %b state %0d, expected 0 0 IDLE",
                  bus.credit, bus.busy, dut.state);
      end
      tick();
      vectors++;
      if (obsQ.size() !== expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL overflow_evcount: got %0d events, expected %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front();
         o = obsQ.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL overflow_event: got kind %0d val %0d, expected kind %0d val %0d",
                     o.kind, o.val, e.kind, e.val);
         end
      end
   endtask

   task automatic test_same_cycle();
      evT e, o;
      itemWord w;
      tableImg = '0;
      setSlot(5, 2, 5);
      setSlot(6, 1, 3);
      doResetAndLoad();
      expQ.push_back('{EvDispense, 8'd5});
      applyStimulus(1, 5, 1, 5, 0);
      vectors++;
      if (bus.credit !== 8'd5) begin
         miscompares++;
         $display("[TB] FAIL same_coinsel: credit %0d, expected 5", bus.credit);
      end
      tick();
      tick();
      tick();
      applyStimulus(1, 7, 0, 0, 0);
      expQ.push_back('{EvChange, 8'd7});
      applyStimulus(0, 0, 1, 6, 1);
      vectors++;
      if (dut.state !== CHANGE) begin
         miscompares++;
         $display("[TB] FAIL same_cancelsel: state %0d, expected CHANGE", dut.state);
      end
      tick();
      applyStimulus(1, 2, 0, 0, 0);
      expQ.push_back('{EvChange, 8'd5});
      applyStimulus(1, 3, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 1);
      vectors++;
      if (dut.state !== IDLE || bus.change_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL same_idlecancel: state %0d change %b, expected IDLE 0",
                  dut.state, bus.change_valid);
      end
      setSlot(6, 4, 3);
      bus.load       = 1'b1;
      bus.stuff_data = tableImg;
      applyStimulus(1, 3, 0, 0, 0);
      expQ.push_back('{EvDispense, 8'd6});
      applyStimulus(0, 0, 1, 6, 0);
      tick();
      tick();
      tick();
      w = dut.stockTable.entries[6];
      vectors++;
      if (stock_of(w) !== 5'd3) begin
         miscompares++;
         $display("[TB] FAIL same_loadcoin: slot6 stock %0d, expected 3", stock_of(w));
      end
      vectors++;
      if (obsQ.size() !== expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL same_evcount: got %0d events, expected %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front();
         o = obsQ.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL same_event: got kind %0d val %0d, expected kind %0d val %0d",
                     o.kind, o.val, e.kind, e.val);
         end
      end
   endtask

   task automatic test_reset_mid();
      evT e, o;
      itemWord w;
      logic [N_ITEMS*ITEM_W-1:0] altImg;
      tableImg = '0;
      setSlot(1, 1, 0);
      setSlot(2, 3, 3);
      doResetAndLoad();
      altImg = tableImg;
      altImg[3*ITEM_W +: ITEM_W] = {5'd2, 6'd0};
      expQ.push_back('{EvDispense, 8'd1});
      applyStimulus(0, 0, 1, 1, 0);
      bus.load       = 1'b1;
      bus.stuff_data = altImg;
      tick();
      bus.load = 1'b0;
      tick();
      tick();
      expQ.push_back('{EvSoldout, 8'd0});
      applyStimulus(0, 0, 1, 3, 0);
      tick();
      applyStimulus(1, 4, 0, 0, 0);
      applyStimulus(0, 0, 1, 2, 0);
      tick();
      vectors++;
      if (bus.dispense_valid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL mid_dispense: valid %b, expected 1", bus.dispense_valid);
      end
      reset = 1'b1;
      #1;
      tick();
      vectors++;
      if ({bus.dispense_valid, bus.change_valid, bus.busy, bus.credit} !== 11'd0 || dut.state !== IDLE) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: disp %b chg %b busy %b credit %0d state %0d, expected all 0 IDLE",
                  bus.dispense_valid, bus.change_valid, bus.busy, bus.credit, dut.state);
      end
      w = dut.stockTable.entries[2];
      vectors++;
      if (w !== '0) begin
         miscompares++;
         $display("[TB] FAIL mid_table: slot2 %h, expected 000", w);
      end
      reset = 1'b0;
      tick();
      expQ.push_back('{EvSoldout, 8'd0});
      applyStimulus(0, 0, 1, 2, 0);
      tick();
      tick();
      vectors++;
      if (obsQ.size() !== expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL mid_evcount: got %0d events, expected %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front();
         o = obsQ.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL mid_event: got kind %0d val %0d, expected kind %0d val %0d",
                     o.kind, o.val, e.kind, e.val);
         end
      end
   endtask

   initial begin
      bus.load       = 1'b0;
      bus.stuff_data = '0;
      bus.coin_valid = 1'b0;
      bus.coin_value = '0;
      bus.sel_valid  = 1'b0;
      bus.sel_item   = '0;
      bus.cancel     = 1'b0;
      tableImg       = '0;
      #2;
      test_reset();
      test_purchase();
      test_soldout();
      test_funds();
      test_overflow();
      test_same_cycle();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
